// File: rtl/mmio_stream_bridge.sv
// Memory-mapped write FIFO bridge: the CPU pushes {tag, data} entries per channel,
// and each channel drains them through a first-word-fall-through valid/ready port.
module mmio_stream_bridge #(
  parameter int          CHANNELS     = 2,
  parameter int          DATA_WIDTH   = 8,
  parameter int          TAG_WIDTH    = 12,
  parameter int          DEPTH        = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h1000,
  parameter bit          AUTO_INC     = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [31:0]                      address,
  input  logic [31:0]                      wdata,
  input  logic [3:0]                       we,
  input  logic                             re,
  output logic [31:0]                      rdata,
  output logic                             hit,
  output logic [CHANNELS-1:0]              out_valid,
  input  logic [CHANNELS-1:0]              out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0]   out_data,
  output logic [CHANNELS*TAG_WIDTH-1:0]    out_tag,
  output logic                             pending
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          EW       = TAG_WIDTH + DATA_WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [31:0] WINDOW   = 32'(16 * CHANNELS);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_TAG    = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  logic [31:0]          rel;
  reg_e                 reg_sel;
  logic                 wr_cyc;
  logic [CHANNELS-1:0]  ch_sel;
  logic [CHANNELS-1:0]  push_req;
  logic [CHANNELS-1:0]  push_ok;
  logic [CHANNELS-1:0]  pop;

  logic [AW-1:0]        wr_ptr_q [CHANNELS];
  logic [AW-1:0]        wr_ptr_d [CHANNELS];
  logic [AW-1:0]        rd_ptr_q [CHANNELS];
  logic [AW-1:0]        rd_ptr_d [CHANNELS];
  logic [AW:0]          count_q  [CHANNELS];
  logic [AW:0]          count_d  [CHANNELS];
  logic [TAG_WIDTH-1:0] tag_q    [CHANNELS];
  logic [TAG_WIDTH-1:0] tag_d    [CHANNELS];
  logic [CHANNELS-1:0]  ovf_q;
  logic [CHANNELS-1:0]  ovf_d;

  logic [EW-1:0]        mem_q [CHANNELS][DEPTH];

  assign rel     = address - BASE_ADDRESS;
  assign hit     = (address >= BASE_ADDRESS) && (rel < WINDOW);
  assign reg_sel = reg_e'(address[3:2]);
  assign wr_cyc  = hit && (we != 4'b0);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    ch_sel   = '0;
    push_req = '0;
    push_ok  = '0;
    pop      = '0;
    ovf_d    = ovf_q;
    for (int n = 0; n < CHANNELS; n++) begin
      wr_ptr_d[n] = wr_ptr_q[n];
      rd_ptr_d[n] = rd_ptr_q[n];
      count_d[n]  = count_q[n];
      tag_d[n]    = tag_q[n];

      ch_sel[n]   = hit && (rel[31:4] == 28'(n));
      pop[n]      = (count_q[n] != '0) && out_ready[n];
      push_req[n] = wr_cyc && ch_sel[n] && (reg_sel == REG_DATA);
      // A full channel still takes a push when its head leaves in the same cycle.
      push_ok[n]  = push_req[n] && ((count_q[n] != FULL_CNT) || pop[n]);

      if (push_ok[n]) wr_ptr_d[n] = wr_ptr_q[n] + AW'(1);
      if (pop[n])     rd_ptr_d[n] = rd_ptr_q[n] + AW'(1);

      case ({push_ok[n], pop[n]})
        2'b10:   count_d[n] = count_q[n] + (AW+1)'(1);
        2'b01:   count_d[n] = count_q[n] - (AW+1)'(1);
        default: count_d[n] = count_q[n];
      endcase

      if (wr_cyc && ch_sel[n] && (reg_sel == REG_TAG))
        tag_d[n] = wdata[TAG_WIDTH-1:0];
      else if (push_ok[n] && AUTO_INC)
        tag_d[n] = tag_q[n] + TAG_WIDTH'(1);

      if (push_req[n] && !push_ok[n])
        ovf_d[n] = 1'b1;
      else if (wr_cyc && ch_sel[n] && (reg_sel == REG_STATUS) && wdata[2])
        ovf_d[n] = 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit && re) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (ch_sel[n]) begin
          case (reg_sel)
            REG_TAG:    rdata = 32'(tag_q[n]);
            REG_STATUS: rdata = {8'h00, 16'(count_q[n]), 5'h00, ovf_q[n],
                                 count_q[n] == FULL_CNT, count_q[n] == '0};
            default:    rdata = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    out_tag   = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      out_valid[n]                          = count_q[n] != '0;
      out_data[n*DATA_WIDTH +: DATA_WIDTH]  = mem_q[n][rd_ptr_q[n]][DATA_WIDTH-1:0];
      out_tag[n*TAG_WIDTH +: TAG_WIDTH]     = mem_q[n][rd_ptr_q[n]][EW-1:DATA_WIDTH];
    end
  end

  assign pending = |out_valid;

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < CHANNELS; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        count_q[n]  <= '0;
        tag_q[n]    <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
        count_q[n]  <= count_d[n];
        tag_q[n]    <= tag_d[n];
      end
      ovf_q <= ovf_d;
    end
  end

  // NOTE: FIFO storage has no reset; zeroed pointers and counts make stale entries invisible.
  always_ff @(posedge clk) begin
    for (int n = 0; n < CHANNELS; n++) begin
      if (push_ok[n] && !rst)
        mem_q[n][wr_ptr_q[n]] <= {tag_q[n], wdata[DATA_WIDTH-1:0]};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{address[1:0], rel[3:0], wdata};

endmodule

// File: tb/tb_mmio_stream_bridge.sv
// Directed bench for mmio_stream_bridge: a queue-level model is compared against the
// drain outputs every cycle, and register reads are checked against model and literals.
module tb_mmio_stream_bridge;

  localparam int          CH    = 2;
  localparam int          DW    = 8;
  localparam int          TW    = 12;
  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h1000;

  logic              clk;
  logic              rst;
  logic [31:0]       address;
  logic [31:0]       wdata;
  logic [3:0]        we;
  logic              re;
  logic [31:0]       rdata;
  logic              hit;
  logic [CH-1:0]     out_valid;
  logic [CH-1:0]     out_ready;
  logic [CH*DW-1:0]  out_data;
  logic [CH*TW-1:0]  out_tag;
  logic              pending;

  mmio_stream_bridge #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH),
    .BASE_ADDRESS(BASE), .AUTO_INC(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .hit(hit), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: one queue of {tag, data} per channel plus tag register and overflow flag.
  logic [TW+DW-1:0] mq [CH][$];
  logic [TW-1:0]    mtag [CH];
  logic             movf [CH];
  bit               model_live = 0;
  int               m_ch;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(16 * CH));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        mq[c].delete();
        mtag[c] = '0;
        movf[c] = 1'b0;
      end
      model_live = 1;
    end else if (model_live) begin
      for (int c = 0; c < CH; c++)
        if (out_ready[c] && mq[c].size() != 0) void'(mq[c].pop_front());
      if (we != 4'b0 && in_win(address)) begin
        m_ch = int'((address - BASE) >> 4);
        case (address[3:2])
          2'd0: begin
            if (mq[m_ch].size() < DEPTH) begin
              mq[m_ch].push_back({mtag[m_ch], wdata[DW-1:0]});
              mtag[m_ch] = mtag[m_ch] + 1'b1;
            end else begin
              movf[m_ch] = 1'b1;
            end
          end
          2'd1: mtag[m_ch] = wdata[TW-1:0];
          2'd2: if (wdata[2]) movf[m_ch] = 1'b0;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    int c;
    r = '0;
    if (in_win(a)) begin
      c = int'((a - BASE) >> 4);
      case (a[3:2])
        2'd1: r = 32'(mtag[c]);
        2'd2: r = {8'h00, 16'(mq[c].size()), 5'h00, movf[c],
                   mq[c].size() == DEPTH, mq[c].size() == 0};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (model_live) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("ch%0d out_valid", c), 32'(out_valid[c]), 32'(mq[c].size() != 0));
        if (mq[c].size() != 0) begin
          check($sformatf("ch%0d out_data", c), 32'(out_data[c*DW +: DW]), 32'(mq[c][0][DW-1:0]));
          check($sformatf("ch%0d out_tag", c), 32'(out_tag[c*TW +: TW]), 32'(mq[c][0][TW+DW-1:DW]));
        end
      end
      check("pending", 32'(pending), 32'(mq[0].size() != 0 || mq[1].size() != 0));
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    wdata   = d;
    we      = 4'hF;
    @(posedge clk);
    #1;
    we = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    re      = 1'b1;
    #1;
    check($sformatf("rdata @%h", a), rdata, model_read(a));
    check($sformatf("hit @%h", a), 32'(hit), 32'(in_win(a)));
    d  = rdata;
    re = 1'b0;
    #1;
    check("rdata idle", rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] v;

  initial begin
    rst = 1'b1; we = 4'h0; re = 1'b0; address = '0; wdata = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    rd(BASE + 8, v);  check("reset status ch0", v, 32'h0000_0001);
    rd(BASE + 4, v);  check("reset tag ch0", v, 32'h0);

    // Two pushes held back by out_ready=0.
    wr(BASE + 4, 32'h100);
    wr(BASE + 0, 32'h41);
    wr(BASE + 0, 32'h42);
    rd(BASE + 8, v);  check("status two queued", v, 32'h0000_0200);
    rd(BASE + 4, v);  check("tag after two pushes", v, 32'h102);
    rd(BASE + 0, v);  check("data reg reads zero", v, 32'h0);

    // Consecutive pops in FIFO order.
    @(negedge clk); out_ready[0] = 1'b1; #1;
    check("head1 data", 32'(out_data[0 +: DW]), 32'h41);
    check("head1 tag", 32'(out_tag[0 +: TW]), 32'h100);
    @(negedge clk); #1;
    check("head2 data", 32'(out_data[0 +: DW]), 32'h42);
    check("head2 tag", 32'(out_tag[0 +: TW]), 32'h101);
    @(negedge clk); out_ready[0] = 1'b0;
    rd(BASE + 8, v);  check("status drained", v, 32'h0000_0001);

    // Overfill: 33 pushes into 32 slots.
    for (int i = 0; i < 33; i++) wr(BASE + 0, 32'(i));
    rd(BASE + 8, v);  check("status full+ovf", v, 32'h0000_2006);
    rd(BASE + 4, v);  check("tag advanced by 32", v, 32'h122);
    wr(BASE + 8, 32'h4);
    rd(BASE + 8, v);  check("status after w1c", v, 32'h0000_2002);

    // Push into a full FIFO while it pops in the same cycle.
    @(negedge clk);
    out_ready[0] = 1'b1; address = BASE; wdata = 32'hAA; we = 4'hF;
    @(posedge clk); #1;
    we = 4'h0; out_ready[0] = 1'b0;
    rd(BASE + 8, v);  check("status full no ovf", v, 32'h0000_2002);
    @(negedge clk); out_ready[0] = 1'b1;
    repeat (31) @(negedge clk);
    out_ready[0] = 1'b0; #1;
    check("late entry data", 32'(out_data[0 +: DW]), 32'hAA);
    check("late entry tag", 32'(out_tag[0 +: TW]), 32'h122);
    @(negedge clk); out_ready[0] = 1'b1;
    @(negedge clk); out_ready[0] = 1'b0;
    rd(BASE + 8, v);  check("status empty again", v, 32'h0000_0001);

    // Channel isolation.
    wr(BASE + 0,  32'hA0);
    wr(BASE + 16, 32'hB0);
    wr(BASE + 0,  32'hA1);
    wr(BASE + 16, 32'hB1);
    wr(BASE + 16, 32'hB2);
    @(negedge clk); out_ready = 2'b10;
    repeat (5) @(negedge clk);
    out_ready = 2'b00;
    rd(BASE + 8, v);  check("ch0 untouched", v, 32'h0000_0200);
    rd(BASE + 24, v); check("ch1 drained", v, 32'h0000_0001);
    rd(BASE + 20, v); check("ch1 tag", v, 32'h3);
    check("pending with ch0 only", 32'(pending), 32'h1);
    @(negedge clk); out_ready = 2'b01;
    repeat (2) @(negedge clk);
    out_ready = 2'b00; #1;
    check("pending all empty", 32'(pending), 32'h0);

    // Reset mid-burst, colliding with a push and ready.
    wr(BASE + 20, 32'h7FF);
    for (int i = 0; i < 5; i++) wr(BASE + 16, 32'(8'hC0 + i));
    rd(BASE + 8 + 16, v); check("ch1 five queued", v, 32'h0000_0500);
    @(negedge clk);
    rst = 1'b1; address = BASE + 16; wdata = 32'h99; we = 4'hF; out_ready = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0; we = 4'h0; out_ready = 2'b00;
    @(negedge clk); #1;
    check("valid after rst", 32'(out_valid), 32'h0);
    check("pending after rst", 32'(pending), 32'h0);
    rd(BASE + 24, v); check("ch1 status after rst", v, 32'h0000_0001);
    rd(BASE + 20, v); check("ch1 tag after rst", v, 32'h0);
    rd(BASE + 8, v);  check("ch0 status after rst", v, 32'h0000_0001);

    // Decode edges.
    rd(BASE + 32, v);      check("above window", v, 32'h0);
    rd(BASE - 4, v);       check("below window", v, 32'h0);
    rd(BASE + 12, v);      check("reserved reg", v, 32'h0);
    rd(BASE + 5 + 16, v);  check("byte offset ignored", v, 32'h0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_stream_bridge.md
Name: mmio_stream_bridge

Overview:
Parametrised, multi-channel, memory-mapped write FIFO bridge between the CPU data bus and slow, busy-gated peripherals such as the VGA terminal.
- Each channel buffers {tag, data} pairs in one FIFO, so data and tag can never desynchronise.
- Each channel exposes DATA, TAG and STATUS registers.
- Each channel drains through a valid/ready handshake.
- Adds two things the two-FIFO VGA path lacks: tag auto-increment and sticky overflow detection.

Parameters:
CHANNELS, 2, number of independent channels (1..8)
DATA_WIDTH, 8, payload width per entry (1..32)
TAG_WIDTH, 12, tag/address width per entry (1..16)
DEPTH, 32, entries per channel FIFO; power of two, 2..32768
BASE_ADDRESS, 32'h1000, byte address of channel 0 register window
AUTO_INC, 1, 1 = TAG register increments after every accepted push; 0 = tag is held

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  synchronous, active-high reset
address  in  32  CPU byte address
wdata  in  32  CPU write data
we  in  4  byte write enables; any nonzero bit = write cycle
re  in  1  read strobe
rdata  out  32  read data; 0 when not (hit && re)
hit  out  1  address decodes into this block's window
out_valid  out  CHANNELS  per-channel head entry valid (FIFO not empty)
out_ready  in  CHANNELS  per-channel consumer ready (e.g. !vga_busy)
out_data  out  CHANNELS*DATA_WIDTH  head payload; channel n at [n*DATA_WIDTH +: DATA_WIDTH]
out_tag  out  CHANNELS*TAG_WIDTH  head tag; channel n at [n*TAG_WIDTH +: TAG_WIDTH]
pending  out  1  OR of out_valid

Behaviour:
- Decode
  - Channel n window is BASE_ADDRESS + 16*n through +15.
  - hit = 1 when address lies in [BASE, BASE + 16*CHANNELS).
  - Address bits [1:0] are ignored.
  - Register offset is address[3:2]: 0 DATA (write-only, reads 0), 1 TAG (R/W), 2 STATUS (R/W1C), 3 reserved (reads 0, writes ignored).
- Reads
  - Combinational, same cycle; rdata = 0 unless hit && re.
  - TAG read: zero-extended tag_reg.
  - STATUS read: bit0 empty, bit1 full, bit2 overflow, bits[23:8] count zero-extended; all other bits 0.
- DATA write (hit, |we, offset 0)
  - Push request of {tag_reg, wdata[DATA_WIDTH-1:0]}.
  - Accepted if count < DEPTH, or if that channel pops in the same cycle.
  - An accepted push when AUTO_INC=1 sets tag_reg <= tag_reg+1, wrapping mod 2^TAG_WIDTH.
  - A rejected push drops the entry, sets that channel's overflow = 1, and leaves tag_reg unchanged.
- TAG write: tag_reg <= wdata[TAG_WIDTH-1:0] on the next edge.
- STATUS write: wdata[2]=1 clears overflow; other bits are ignored.
- Drain side
  - First-word fall-through: out_valid[n] = (count != 0); out_data and out_tag show the head entry combinationally.
  - A pop occurs when out_valid && out_ready.
  - out_ready with the FIFO empty has no effect.
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance. This also applies when full, or when count = 1; in the count = 1 case the new entry becomes head on the next cycle.
- Counters and pointers
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits and saturates by construction at 0..DEPTH.
- Channel isolation: each channel has independent FIFO, tag_reg and overflow; at most one channel is written per cycle.
- Reset
  - rst=1 on a clock edge zeroes every pointer, count, tag_reg and overflow.
  - Outputs next cycle: out_valid = 0, pending = 0.
  - FIFO storage is not cleared; head outputs are don't-care while out_valid = 0.
  - rst has priority over a simultaneous push, pop or register write.
- Latency
  - A write on edge k makes the entry visible on out_valid/out_data after edge k (1 cycle).
  - A STATUS read reflects state after the most recent edge.

Test Plan:
- Reset, then write TAG ch0 = 12'h100, then DATA ch0 = 8'h41, 8'h42 with out_ready=0 -> STATUS ch0 = 32'h0000_0200; tag_reg reads 12'h102.
- Set out_ready[0]=1 -> two pops in consecutive cycles: (41,100) then (42,101); STATUS = 32'h0000_0001.
- Write 33 DATA ch0 with out_ready=0, DEPTH=32 -> count 32, full=1, overflow=1, tag advanced by exactly 32; STATUS W1C with wdata=4 -> overflow 0, full still 1.
- Full FIFO, push while out_ready=1 in the same cycle -> accepted, no overflow, count stays 32, entry appears after 31 further pops.
- Interleave ch0 and ch1 (BASE+16) writes; toggle ch1 ready only -> ch0 untouched; pending = 1 until both are empty.
- Assert rst mid-burst with 5 entries queued -> next cycle out_valid = 0, STATUS = 1, TAG = 0; address outside the window -> hit = 0, rdata = 0.
